obi_rr_arbiter: RTL

//  Round-robin arbiter sharing the single OBI initiator port of the APB-split interconnect between
//  NUM_REQ OBI requesters (e.g. core data port, debug module, DMA). Sequences one transaction at a

---
 rtl/obi_rr_arbiter.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/obi_rr_arbiter.sv
// rtl/obi_rr_arbiter.sv - round-robin arbiter sharing one OBI initiator port among NUM_REQ requesters
// Optional response timeout with DRAIN state: define OBI_ARB_TIMEOUT_EN.
module obi_rr_arbiter #(
   parameter int NUM_REQ     = 2,
   parameter int OBI_AW      = 32,
   parameter int OBI_DW      = 32,
   parameter int OBI_IDW     = 2,
   parameter int TIMEOUT_CYC = 256
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         s_req,
   output logic [NUM_REQ-1:0]         s_gnt,
   input  logic [NUM_REQ*OBI_AW-1:0]  s_addr,
   input  logic [NUM_REQ-1:0]         s_we,
   input  logic [NUM_REQ*OBI_DW/8-1:0] s_be,
   input  logic [NUM_REQ*OBI_DW-1:0]  s_wdata,
   output logic [NUM_REQ-1:0]         s_rvalid,
   input  logic [NUM_REQ-1:0]         s_rready,
   output logic [OBI_DW-1:0]          s_rdata,
   output logic                       s_err,
   output logic                       m_req,
   output logic                       m_reqpar,
   input  logic                       m_gnt,
   output logic [OBI_AW-1:0]          m_addr,
   output logic                       m_we,
   output logic [OBI_DW/8-1:0]        m_be,
   output logic [OBI_DW-1:0]          m_wdata,
   output logic [OBI_IDW-1:0]         m_aid,
   input  logic                       m_rvalid,
   output logic                       m_rready,
   output logic                       m_rreadypar,
   input  logic [OBI_DW-1:0]          m_rdata,
   input  logic                       m_err,
   input  logic [OBI_IDW-1:0]         m_rid,
   output logic                       timeout_flag
);

   localparam int SW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int BW = OBI_DW / 8;

`ifdef OBI_ARB_TIMEOUT_EN
   typedef enum logic [1:0] {IDLE, ADDR, RESP, DRAIN} state_t;
`else
   typedef enum logic [1:0] {IDLE, ADDR, RESP} state_t;
`endif

   state_t        state;
   logic [SW-1:0] rr_ptr;
   logic [SW-1:0] sel;
   logic [SW-1:0] next_sel;
   logic [SW-1:0] next_ptr;
   logic [SW:0]   scan;
   logic          found;
   logic          to_fire;

   // Only one transaction is ever outstanding, so the response ID carries no information.
   logic unused_rid;
   assign unused_rid = ^m_rid;

   always_comb begin
      next_sel = rr_ptr;
      found    = 1'b0;
      scan     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan = {1'b0, rr_ptr} + (SW+1)'(k);
         if (scan >= (SW+1)'(NUM_REQ)) scan = scan - (SW+1)'(NUM_REQ);
         if (!found && s_req[scan[SW-1:0]]) begin
            next_sel = scan[SW-1:0];
            found    = 1'b1;
         end
      end
   end

   assign next_ptr = (sel == SW'(NUM_REQ-1)) ? '0 : sel + 1'b1;

   assign m_addr      = s_addr[int'(sel)*OBI_AW +: OBI_AW];
   assign m_we        = s_we[sel];
   assign m_be        = s_be[int'(sel)*BW +: BW];
   assign m_wdata     = s_wdata[int'(sel)*OBI_DW +: OBI_DW];
   assign m_aid       = OBI_IDW'(sel);
   assign m_reqpar    = ~m_req;
   assign m_rreadypar = ~m_rready;

`ifdef OBI_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CW-1:0] CNT_LIM = CW'(TIMEOUT_CYC - 1);

   logic [CW-1:0] cnt;
   logic          to_hold;

   // Once fired, the synthetic error response must stay stable even if a late m_rvalid shows up.
   assign to_fire = (state == RESP) && (to_hold || (cnt == CNT_LIM && !m_rvalid));
`else
   localparam int unused_timeout_cyc = TIMEOUT_CYC;
   assign to_fire      = 1'b0;
   assign timeout_flag = 1'b0;
`endif

   always_comb begin
      s_gnt    = '0;
      s_rvalid = '0;
      s_rdata  = '0;
      s_err    = 1'b0;
      m_rready = 1'b1;
      case (state)
         ADDR: s_gnt[sel] = m_gnt;
         RESP: begin
            if (to_fire) begin
               s_rvalid[sel] = 1'b1;
               s_err         = 1'b1;
               m_rready      = 1'b0;
            end else begin
               s_rvalid[sel] = m_rvalid;
               m_rready      = s_rready[sel];
               if (m_rvalid) begin
                  s_rdata = m_rdata;
                  s_err   = m_err;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         rr_ptr <= '0;
         sel    <= '0;
         m_req  <= 1'b0;
`ifdef OBI_ARB_TIMEOUT_EN
         cnt          <= '0;
         to_hold      <= 1'b0;
         timeout_flag <= 1'b0;
`endif
      end else begin
`ifdef OBI_ARB_TIMEOUT_EN
         timeout_flag <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (|s_req) begin
                  sel   <= next_sel;
                  m_req <= 1'b1;
                  state <= ADDR;
               end
            end
            ADDR: begin
               if (m_gnt) begin
                  m_req <= 1'b0;
                  state <= RESP;
`ifdef OBI_ARB_TIMEOUT_EN
                  cnt     <= '0;
                  to_hold <= 1'b0;
`endif
               end
            end
            RESP: begin
`ifdef OBI_ARB_TIMEOUT_EN
               if (to_fire) begin
                  if (s_rready[sel]) begin
                     timeout_flag <= 1'b1;
                     to_hold      <= 1'b0;
                     cnt          <= '0;
                     rr_ptr       <= next_ptr;
                     state        <= DRAIN;
                  end else begin
                     to_hold <= 1'b1;
                  end
               end else if (m_rvalid && m_rready) begin
                  rr_ptr <= next_ptr;
                  state  <= IDLE;
               end else if (!m_rvalid && cnt != CNT_LIM) begin
                  cnt <= cnt + 1'b1;
               end
`else
               if (m_rvalid && m_rready) begin
                  rr_ptr <= next_ptr;
                  state  <= IDLE;
               end
`endif
            end
`ifdef OBI_ARB_TIMEOUT_EN
            DRAIN: begin
               if (m_rvalid || cnt == CNT_LIM) state <= IDLE;
               else cnt <= cnt + 1'b1;
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule
